// File: rtl/mc_seq_if.sv
// Signal bundle between the multi-cycle sequencing controller and the datapath.
// The master modport is the controller side; the slave modport is the datapath/decoder side.
interface mc_seq_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        branch_taken;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic        ir_write;
  logic        mem_rd;
  logic        mem_wr;
  logic        i_or_d;
  logic        reg_wr;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        retire;
  logic [31:0] inst_count;
  logic        trap;

  modport master (
    input  op, funct, mem_ready, branch_taken,
    output pc_write, pc_sel, ir_write, mem_rd, mem_wr, i_or_d,
           reg_wr, wb_sel, state, retire, inst_count, trap
  );

  modport slave (
    output op, funct, mem_ready, branch_taken,
    input  pc_write, pc_sel, ir_write, mem_rd, mem_wr, i_or_d,
           reg_wr, wb_sel, state, retire, inst_count, trap
  );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle MIPS sequencing controller: FETCH/DECODE/EXEC/MEM/WB/LINK with Mealy strobes.
// Optional feature: define ILLEGAL_TRAP_EN to send unmatched opcodes to a sticky TRAP state.
module mc_seq_ctrl (
  input  logic     clk,
  input  logic     rst,
  mc_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_LINK   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BR, C_J, C_JAL, C_JR, C_JALR, C_NONE
  } iclass_t;

  state_t      state_q, state_d;
  iclass_t     iclass;
  logic [31:0] count_q;
  logic        trap_int;
  logic        pc_write, ir_write, mem_rd, mem_wr, i_or_d, reg_wr, retire;
  logic [1:0]  pc_sel, wb_sel;

  // Instruction class from the latched IR; only meaningful from DECODE onward.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    iclass = C_NONE;
    case (bus.op)
      6'h00: begin
        case (bus.funct)
          6'h08: iclass = C_JR;
          6'h09: iclass = C_JALR;
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B: iclass = C_ALU_R;
          default: ;
        endcase
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: iclass = C_BR;
      6'h02: iclass = C_J;
      6'h03: iclass = C_JAL;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: iclass = C_ALU_I;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: iclass = C_LOAD;
      6'h28, 6'h29, 6'h2B: iclass = C_STORE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (iclass)
          C_J, C_JR:     state_d = S_FETCH;
          C_JAL, C_JALR: state_d = S_LINK;
`ifdef ILLEGAL_TRAP_EN
          C_NONE:        state_d = S_TRAP;
`else
          C_NONE:        state_d = S_FETCH;
`endif
          default:       state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (iclass == C_BR)                              state_d = S_FETCH;
        else if (iclass == C_LOAD || iclass == C_STORE) state_d = S_MEM;
        else                                            state_d = S_WB;
      end
      S_MEM:    if (bus.mem_ready) state_d = (iclass == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_LINK:   state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Mealy strobes; reset forces them all low in the same cycle.
  always_comb begin
    pc_write = 1'b0;
    pc_sel   = 2'd0;
    ir_write = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    i_or_d   = 1'b0;
    reg_wr   = 1'b0;
    wb_sel   = 2'd0;
    retire   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_rd = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (iclass == C_J) begin
            pc_write = 1'b1;
            pc_sel   = 2'd2;
            retire   = 1'b1;
          end else if (iclass == C_JR) begin
            pc_write = 1'b1;
            pc_sel   = 2'd3;
            retire   = 1'b1;
          end
`ifndef ILLEGAL_TRAP_EN
          else if (iclass == C_NONE) begin
            retire = 1'b1;
          end
`endif
        end
        S_EXEC: begin
          if (iclass == C_BR) begin
            pc_write = bus.branch_taken;
            pc_sel   = 2'd1;
            retire   = 1'b1;
          end
        end
        S_MEM: begin
          i_or_d = 1'b1;
          mem_rd = (iclass == C_LOAD);
          mem_wr = (iclass == C_STORE);
          retire = bus.mem_ready && (iclass == C_STORE);
        end
        S_WB: begin
          reg_wr = 1'b1;
          wb_sel = (iclass == C_LOAD) ? 2'd1 : 2'd0;
          retire = 1'b1;
        end
        S_LINK: begin
          reg_wr   = 1'b1;
          wb_sel   = 2'd2;
          pc_write = 1'b1;
          pc_sel   = (iclass == C_JAL) ? 2'd2 : 2'd3;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         count_q <= '0;
    else if (retire) count_q <= count_q + 32'd1;
  end

`ifdef ILLEGAL_TRAP_EN
  assign trap_int = (state_q == S_TRAP);
`else
  assign trap_int = 1'b0;
`endif

  assign bus.pc_write   = pc_write;
  assign bus.pc_sel     = pc_sel;
  assign bus.ir_write   = ir_write;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.i_or_d     = i_or_d;
  assign bus.reg_wr     = reg_wr;
  assign bus.wb_sel     = wb_sel;
  assign bus.retire     = retire;
  assign bus.state      = rst ? 3'd0 : state_q;
  assign bus.inst_count = rst ? 32'd0 : count_q;
  assign bus.trap       = trap_int & ~rst;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Self-checking bench for mc_seq_ctrl: per-instruction cycle schedules built from the
// instruction-class rules, randomized waits/opcodes, per-cycle compare plus literal CPI checks.
module tb_mc_seq_ctrl;

  localparam int K_ALUR = 0, K_ALUI = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4,
                 K_J = 5, K_JAL = 6, K_JR = 7, K_JALR = 8, K_ILL = 9;

  typedef struct packed {
    logic [2:0]  state;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        ir_write;
    logic        mem_rd;
    logic        mem_wr;
    logic        i_or_d;
    logic        reg_wr;
    logic [1:0]  wb_sel;
    logic        retire;
    logic [31:0] inst_count;
    logic        trap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_seq_if bus();

  mc_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          run_len  = 0;
  int          last_len = 0;
  exp_t        exp_q[$];
  logic [31:0] model_count = '0;
  logic [5:0]  ir_op = '0;
  logic [5:0]  ir_funct = '0;

  logic [5:0] r_functs [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] ld_ops  [5]  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  logic [5:0] st_ops  [3]  = '{6'h28, 6'h29, 6'h2B};
  logic [5:0] br_ops  [5]  = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01};
  logic [5:0] ill_ops [4]  = '{6'h3F, 6'h10, 6'h22, 6'h2A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t blank(input logic [2:0] s);
    exp_t e = '0;
    e.state = s;
    return e;
  endfunction

  function automatic logic rb();
    return ($urandom() & 32'd1) != 32'd0;
  endfunction

  // One clock cycle: drive inputs just after the edge, queue what the outputs must be.
  task automatic step(input exp_t e, input logic mr, input logic bt, input logic r = 1'b0);
    @(posedge clk);
    #1;
    rst              = r;
    bus.op           = ir_op;
    bus.funct        = ir_funct;
    bus.mem_ready    = mr;
    bus.branch_taken = bt;
    if (r) begin
      exp_q.push_back('0);
      model_count = '0;
    end else begin
      e.inst_count = model_count;
      exp_q.push_back(e);
      if (e.retire) model_count = model_count + 32'd1;
    end
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic do_fetch(input int fw);
    exp_t e;
    for (int k = 0; k < fw; k++) begin
      e = blank(3'd0);
      e.mem_rd = 1'b1;
      step(e, 1'b0, rb());
    end
    e = blank(3'd0);
    e.mem_rd   = 1'b1;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    step(e, 1'b1, rb());
  endtask

  // Full instruction schedule from its class; for a trapping illegal op it stops after DECODE.
  task automatic run_inst(input int cls, input logic [5:0] op, input logic [5:0] funct,
                          input int fw, input int mw, input logic bt);
    exp_t e;
    do_fetch(fw);
    ir_op    = op;
    ir_funct = funct;
    e = blank(3'd1);
    case (cls)
      K_J, K_JR: begin
        e.pc_write = 1'b1;
        e.pc_sel   = (cls == K_J) ? 2'd2 : 2'd3;
        e.retire   = 1'b1;
        step(e, rb(), rb());
        return;
      end
      K_JAL, K_JALR: begin
        step(e, rb(), rb());
        e = blank(3'd5);
        e.reg_wr   = 1'b1;
        e.wb_sel   = 2'd2;
        e.pc_write = 1'b1;
        e.pc_sel   = (cls == K_JAL) ? 2'd2 : 2'd3;
        e.retire   = 1'b1;
        step(e, rb(), rb());
        return;
      end
      K_ILL: begin
`ifndef ILLEGAL_TRAP_EN
        e.retire = 1'b1;
`endif
        step(e, rb(), rb());
        return;
      end
      default: step(e, rb(), rb());
    endcase
    e = blank(3'd2);
    if (cls == K_BR) begin
      e.pc_write = bt;
      e.pc_sel   = 2'd1;
      e.retire   = 1'b1;
      step(e, rb(), bt);
      return;
    end
    step(e, rb(), rb());
    if (cls == K_LOAD || cls == K_STORE) begin
      e = blank(3'd3);
      e.i_or_d = 1'b1;
      e.mem_rd = (cls == K_LOAD);
      e.mem_wr = (cls == K_STORE);
      for (int k = 0; k < mw; k++) step(e, 1'b0, rb());
      e.retire = (cls == K_STORE);
      step(e, 1'b1, rb());
      if (cls == K_STORE) return;
    end
    e = blank(3'd4);
    e.reg_wr = 1'b1;
    e.wb_sel = (cls == K_LOAD) ? 2'd1 : 2'd0;
    e.retire = 1'b1;
    step(e, rb(), rb());
  endtask

  // Compare process: every cycle with a queued expectation is checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",      32'(bus.state),      32'(e.state));
        check("pc_write",   32'(bus.pc_write),   32'(e.pc_write));
        check("pc_sel",     32'(bus.pc_sel),     32'(e.pc_sel));
        check("ir_write",   32'(bus.ir_write),   32'(e.ir_write));
        check("mem_rd",     32'(bus.mem_rd),     32'(e.mem_rd));
        check("mem_wr",     32'(bus.mem_wr),     32'(e.mem_wr));
        check("i_or_d",     32'(bus.i_or_d),     32'(e.i_or_d));
        check("reg_wr",     32'(bus.reg_wr),     32'(e.reg_wr));
        check("wb_sel",     32'(bus.wb_sel),     32'(e.wb_sel));
        check("retire",     32'(bus.retire),     32'(e.retire));
        check("inst_count", bus.inst_count,      e.inst_count);
        check("trap",       32'(bus.trap),       32'(e.trap));
      end
      run_len++;
      if (bus.retire === 1'b1) begin
        last_len = run_len;
        run_len  = 0;
      end
      if (rst) run_len = 0;
    end
  end

  initial begin
    exp_t       e;
    int         cls;
    logic [5:0] op, funct;

    bus.op           = '0;
    bus.funct        = '0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;

    step(blank(3'd0), 1'b1, 1'b1, 1'b1);
    step(blank(3'd0), 1'b1, 1'b1, 1'b1);

    run_inst(K_ALUR, 6'h00, 6'h21, 0, 0, 1'b0);
    sync(); check("len_addu", last_len, 4);
    run_inst(K_LOAD, 6'h23, 6'h00, 0, 2, 1'b0);
    sync(); check("len_lw", last_len, 7);
    check("count_after_addu", bus.inst_count, 1);
    run_inst(K_BR, 6'h04, 6'h00, 0, 0, 1'b1);
    sync(); check("len_beq", last_len, 3);
    run_inst(K_BR, 6'h05, 6'h00, 0, 0, 1'b0);
    sync(); check("len_bne", last_len, 3);
    run_inst(K_JAL, 6'h03, 6'h00, 0, 0, 1'b0);
    sync(); check("len_jal", last_len, 3);
    run_inst(K_JR, 6'h00, 6'h08, 0, 0, 1'b0);
    sync(); check("len_jr", last_len, 2);
    run_inst(K_JALR, 6'h00, 6'h09, 0, 0, 1'b0);
    sync(); check("len_jalr", last_len, 3);
    run_inst(K_ALUI, 6'h09, 6'h15, 2, 0, 1'b0);
    sync(); check("len_addiu_fetch_wait", last_len, 6);

    // sw aborted by reset while waiting in MEM
    do_fetch(0);
    sync(); check("count_before_rst", bus.inst_count, 8);
    ir_op = 6'h2B;
    ir_funct = 6'h00;
    step(blank(3'd1), rb(), rb());
    step(blank(3'd2), rb(), rb());
    e = blank(3'd3);
    e.i_or_d = 1'b1;
    e.mem_wr = 1'b1;
    step(e, 1'b0, rb());
    step(blank(3'd0), 1'b0, rb(), 1'b1);

    for (int n = 0; n < 150; n++) begin
`ifdef ILLEGAL_TRAP_EN
      cls = $urandom_range(0, 8);
`else
      cls = $urandom_range(0, 9);
`endif
      funct = 6'($urandom());
      case (cls)
        K_ALUR:  begin op = 6'h00; funct = r_functs[$urandom_range(0, 15)]; end
        K_ALUI:  op = 6'h08 + 6'($urandom_range(0, 7));
        K_LOAD:  op = ld_ops[$urandom_range(0, 4)];
        K_STORE: op = st_ops[$urandom_range(0, 2)];
        K_BR:    op = br_ops[$urandom_range(0, 4)];
        K_J:     op = 6'h02;
        K_JAL:   op = 6'h03;
        K_JR:    begin op = 6'h00; funct = 6'h08; end
        K_JALR:  begin op = 6'h00; funct = 6'h09; end
        default: begin
          if ($urandom_range(0, 4) == 0) begin
            op = 6'h00;
            funct = 6'h01;
          end else begin
            op = ill_ops[$urandom_range(0, 3)];
          end
        end
      endcase
      run_inst(cls, op, funct, $urandom_range(0, 2), $urandom_range(0, 2), rb());
    end

`ifdef ILLEGAL_TRAP_EN
    run_inst(K_ILL, 6'h3F, 6'h00, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      e = blank(3'd6);
      e.trap = 1'b1;
      step(e, rb(), rb());
    end
    sync();
    check("trap_state", 32'(bus.state), 6);
    check("trap_flag", 32'(bus.trap), 1);
    step(blank(3'd0), rb(), rb(), 1'b1);
    run_inst(K_ALUR, 6'h00, 6'h20, 0, 0, 1'b0);
    sync(); check("len_add_after_trap", last_len, 4);
`else
    run_inst(K_ILL, 6'h3F, 6'h00, 0, 0, 1'b0);
    sync();
    check("len_illegal_nop", last_len, 2);
    check("trap_tied_low", 32'(bus.trap), 0);
`endif

    sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
